// File: rtl/pacman_pkg.sv
// pacman_pkg: constants and types shared by the Pac-Man blocks.
//   Tile geometry, map limits, sprite width, colour constants, direction codes,
//   plotter state encoding and tile-to-pixel coordinate helpers.
package pacman_pkg;

  localparam int unsigned TILE      = 5;
  localparam int unsigned MAP_MAX_X = 26;
  localparam int unsigned MAP_MAX_Y = 23;
  localparam int unsigned SHAPE_W   = 25;

  localparam logic [2:0] COLOUR_PAC = 3'b110;
  localparam logic [2:0] COLOUR_BG  = 3'b000;

  typedef enum logic [2:0] {
    DirWait  = 3'd0,
    DirRight = 3'd1,
    DirUp    = 3'd2,
    DirLeft  = 3'd3,
    DirDown  = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StErase = 2'd1,
    StDraw  = 2'd2,
    StDone  = 2'd3
  } plot_state_e;

  // 8-bit arithmetic on purpose: out-of-range tiles wrap rather than clamp.
  function automatic logic [7:0] pixel_x(logic [7:0] tile_x, logic [2:0] col);
    logic [7:0] base;
    base = tile_x * 8'(TILE);
    return base + {5'b0, col};
  endfunction

  function automatic logic [6:0] pixel_y(logic [6:0] tile_y, logic [2:0] row);
    logic [6:0] base;
    base = tile_y * 7'(TILE);
    return base + {4'b0, row};
  endfunction

  function automatic logic [4:0] shape_idx(logic [2:0] row, logic [2:0] col);
    return ({2'b0, row} * 5'(TILE)) + {2'b0, col};
  endfunction

endpackage

// File: rtl/tile_pixel_counter.sv
// tile_pixel_counter: walks the 5x5 pixels of one tile, col inner, row outer.
//   clock    in   system clock
//   reset_n  in   synchronous active-low reset
//   i_clear  in   return to (0,0); wins over i_inc
//   i_inc    in   advance one pixel, wrapping (4,4) -> (0,0)
//   o_col    out  current column 0..4
//   o_row    out  current row 0..4
//   o_last   out  high at (4,4)
module tile_pixel_counter
  import pacman_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_inc,
  output logic [2:0] o_col,
  output logic [2:0] o_row,
  output logic       o_last
);

  localparam logic [2:0] LastIdx = 3'(TILE - 1);

  logic [2:0] r_col;
  logic [2:0] r_row;

  always_ff @(posedge clock) begin
    if (!reset_n || i_clear) begin
      r_col <= 3'd0;
      r_row <= 3'd0;
    end else if (i_inc) begin
      if (r_col == LastIdx) begin
        r_col <= 3'd0;
        r_row <= (r_row == LastIdx) ? 3'd0 : r_row + 3'd1;
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == LastIdx) && (r_row == LastIdx);

endmodule

// File: rtl/pacman_plotter.sv
// pacman_plotter: on each go rising edge, erases the sprite at the previous tile and draws
//   the new 5x5 sprite at the new tile, one pixel per clock into the VGA adapter write port.
//   clock       in   system clock
//   reset_n     in   synchronous active-low reset
//   go          in   frame tick; request = rising edge
//   x_in/y_in   in   new tile coordinates (8b / 7b)
//   shape_in    in   25-bit sprite, bit row*5+col, row 0 top, col 0 left
//   vga_x/vga_y out  pixel coordinates
//   vga_colour  out  pixel colour
//   vga_plot    out  write strobe
//   busy        out  high while erasing, drawing or finishing a frame
//   done        out  one-cycle end-of-frame pulse
// Build option: PLOTTER_SKIP_SAME_EN skips the erase pass when the new tile equals the old.
module pacman_plotter
  import pacman_pkg::*;
#(
  parameter logic [2:0] PAC_COLOUR = COLOUR_PAC,
  parameter logic [2:0] BG_COLOUR  = COLOUR_BG,
  parameter logic [7:0] RESET_X    = 8'd0,
  parameter logic [6:0] RESET_Y    = 7'd0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic [7:0]           x_in,
  input  logic [6:0]           y_in,
  input  logic [SHAPE_W-1:0]   shape_in,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 done
);

  plot_state_e        r_state;
  logic               r_go_q;
  logic               r_pending;
  logic [7:0]         r_prev_x, r_cur_x, r_pend_x;
  logic [6:0]         r_prev_y, r_cur_y, r_pend_y;
  logic [SHAPE_W-1:0] r_cur_shape, r_pend_shape;
  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic [2:0]         r_colour;
  logic               r_plot, r_busy, r_done;

  logic               w_edge;
  logic               w_active;
  logic [2:0]         w_col, w_row;
  logic               w_last;
  logic [7:0]         w_launch_x;
  logic [6:0]         w_launch_y;
  logic [SHAPE_W-1:0] w_launch_shape;
  logic               w_skip;

  assign w_edge   = go & ~r_go_q;
  assign w_active = (r_state == StErase) || (r_state == StDraw);

  tile_pixel_counter u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (~w_active),
    .i_inc   (w_active),
    .o_col   (w_col),
    .o_row   (w_row),
    .o_last  (w_last)
  );

  // In DONE a fresh edge beats an older pending request; otherwise take the live inputs.
  assign w_launch_x     = (r_state == StDone && !w_edge) ? r_pend_x     : x_in;
  assign w_launch_y     = (r_state == StDone && !w_edge) ? r_pend_y     : y_in;
  assign w_launch_shape = (r_state == StDone && !w_edge) ? r_pend_shape : shape_in;

`ifdef PLOTTER_SKIP_SAME_EN
  // In DONE the current tile is about to become the previous one.
  logic [7:0] w_ref_x;
  logic [6:0] w_ref_y;
  assign w_ref_x = (r_state == StDone) ? r_cur_x : r_prev_x;
  assign w_ref_y = (r_state == StDone) ? r_cur_y : r_prev_y;
  assign w_skip  = (w_launch_x == w_ref_x) && (w_launch_y == w_ref_y);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_go_q       <= 1'b0;
      r_pending    <= 1'b0;
      r_prev_x     <= RESET_X;
      r_prev_y     <= RESET_Y;
      r_cur_x      <= 8'd0;
      r_cur_y      <= 7'd0;
      r_cur_shape  <= '0;
      r_pend_x     <= 8'd0;
      r_pend_y     <= 7'd0;
      r_pend_shape <= '0;
      r_x          <= 8'd0;
      r_y          <= 7'd0;
      r_colour     <= 3'd0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_go_q <= go;
      r_plot <= 1'b0;
      r_done <= 1'b0;

      // Requests arriving mid-frame are parked; the latest one wins.
      if (w_edge && w_active) begin
        r_pending    <= 1'b1;
        r_pend_x     <= x_in;
        r_pend_y     <= y_in;
        r_pend_shape <= shape_in;
      end

      unique case (r_state)
        StIdle: begin
          r_busy <= 1'b0;
          if (w_edge) begin
            r_cur_x     <= w_launch_x;
            r_cur_y     <= w_launch_y;
            r_cur_shape <= w_launch_shape;
            r_state     <= w_skip ? StDraw : StErase;
          end
        end
        StErase: begin
          r_busy   <= 1'b1;
          r_plot   <= 1'b1;
          r_x      <= pixel_x(r_prev_x, w_col);
          r_y      <= pixel_y(r_prev_y, w_row);
          r_colour <= BG_COLOUR;
          if (w_last) r_state <= StDraw;
        end
        StDraw: begin
          r_busy   <= 1'b1;
          r_plot   <= 1'b1;
          r_x      <= pixel_x(r_cur_x, w_col);
          r_y      <= pixel_y(r_cur_y, w_row);
          r_colour <= r_cur_shape[shape_idx(w_row, w_col)] ? PAC_COLOUR : BG_COLOUR;
          if (w_last) r_state <= StDone;
        end
        StDone: begin
          r_busy    <= 1'b1;
          r_done    <= 1'b1;
          r_prev_x  <= r_cur_x;
          r_prev_y  <= r_cur_y;
          r_pending <= 1'b0;
          if (w_edge || r_pending) begin
            r_cur_x     <= w_launch_x;
            r_cur_y     <= w_launch_y;
            r_cur_shape <= w_launch_shape;
            r_state     <= w_skip ? StDraw : StErase;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_pacman_plotter.sv
// tb_pacman_plotter: drives pacman_plotter with directed and random go requests and compares
// every output cycle against a queue of expected pixel records built from the frame rules.
module tb_pacman_plotter;

  logic        clock;
  logic        reset_n;
  logic        go;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [24:0] shape_in;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  pacman_plotter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .go         (go),
    .x_in       (x_in),
    .y_in       (y_in),
    .shape_in   (shape_in),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit plot;
    bit bsy;
    bit dn;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_prev_x, m_prev_y;
  int          m_pend_x, m_pend_y;
  logic [24:0] m_pend_s;
  bit          m_pending;
  bit          m_go_q;
  int          held_x, held_y, held_c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame: 25 background pixels over the old tile (unless skipped), 25 sprite pixels,
  // then a done cycle.
  task automatic push_frame(input int cx, input int cy, input logic [24:0] s);
    exp_t e;
    bit   same;
    same = 1'b0;
`ifdef PLOTTER_SKIP_SAME_EN
    same = (cx == m_prev_x) && (cy == m_prev_y);
`endif
    if (!same) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          e = '{1, 1, 0, (m_prev_x * 5 + c) % 256, (m_prev_y * 5 + r) % 128, 0};
          exp_q.push_back(e);
        end
      end
    end
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        e = '{1, 1, 0, (cx * 5 + c) % 256, (cy * 5 + r) % 128, s[r * 5 + c] ? 6 : 0};
        exp_q.push_back(e);
      end
    end
    e = '{0, 1, 1, 0, 0, 0};
    exp_q.push_back(e);
    m_prev_x = cx;
    m_prev_y = cy;
  endtask

  // Apply inputs for the next rising edge, update the model, then check that edge's outputs.
  task automatic step(input bit rst_n, input bit g, input int xi, input int yi,
                      input logic [24:0] s);
    exp_t e;
    bit   edge_seen;
    int   x, y;
    x = xi % 256;
    y = yi % 128;
    reset_n  = rst_n;
    go       = g;
    x_in     = x[7:0];
    y_in     = y[6:0];
    shape_in = s;
    if (!rst_n) begin
      exp_q.delete();
      m_pending = 0;
      m_prev_x  = 0;
      m_prev_y  = 0;
      m_go_q    = 0;
      held_x    = 0;
      held_y    = 0;
      held_c    = 0;
    end else begin
      edge_seen = g && !m_go_q;
      m_go_q    = g;
      if (edge_seen) begin
        if (exp_q.size() == 0) begin
          e = '{0, 0, 0, 0, 0, 0};
          exp_q.push_back(e);
          push_frame(x, y, s);
        end else if (exp_q[0].dn) begin
          m_pending = 0;
          push_frame(x, y, s);
        end else begin
          m_pending = 1;
          m_pend_x  = x;
          m_pend_y  = y;
          m_pend_s  = s;
        end
      end else if (m_pending && exp_q.size() != 0 && exp_q[0].dn) begin
        m_pending = 0;
        push_frame(m_pend_x, m_pend_y, m_pend_s);
      end
    end
    @(posedge clock);
    @(negedge clock);
    if (exp_q.size() == 0) e = '{0, 0, 0, 0, 0, 0};
    else e = exp_q.pop_front();
    check_eq("plot", vga_plot, e.plot);
    check_eq("busy", busy, e.bsy);
    check_eq("done", done, e.dn);
    if (e.plot) begin
      held_x = e.x;
      held_y = e.y;
      held_c = e.c;
    end
    check_eq("vga_x", vga_x, held_x);
    check_eq("vga_y", vga_y, held_y);
    check_eq("colour", vga_colour, held_c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step(1, 0, 0, 0, 25'h0);
      n++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    step(1, 0, 0, 0, 25'h0);
    step(1, 0, 0, 0, 25'h0);
  endtask

  initial begin
    bit          g;
    bit          rst;
    int          x, y;
    logic [24:0] s;
    reset_n  = 1'b0;
    go       = 1'b0;
    x_in     = '0;
    y_in     = '0;
    shape_in = '0;
    m_pending = 0;
    m_go_q    = 0;
    m_prev_x  = 0;
    m_prev_y  = 0;
    held_x    = 0;
    held_y    = 0;
    held_c    = 0;

    // Reset held three cycles: all outputs zero.
    repeat (3) step(0, 0, 0, 0, 25'h0);

    // First frame after reset: erase at tile (0,0), solid sprite at (2,3).
    repeat (4) step(1, 1, 2, 3, 25'h1FF_FFFF);
    drain();

    // Corner tile, single lit pixel at the top-left.
    step(1, 1, 26, 23, 25'h1);
    drain();

    // Two requests while busy: only the later one is drawn.
    step(1, 1, 1, 1, 25'h0AB_CDEF);
    repeat (5) step(1, 0, 0, 0, 25'h0);
    step(1, 1, 5, 5, 25'h155_5555);
    step(1, 0, 0, 0, 25'h0);
    step(1, 1, 7, 7, 25'h0F0_F0F0);
    drain();

    // Two frames at the same tile.
    step(1, 1, 9, 9, 25'h123_4567);
    drain();
    step(1, 1, 9, 9, 25'h0FE_DCBA);
    drain();

    // Reset in the middle of the draw pass, then a new frame erases the reset tile.
    step(1, 1, 4, 4, 25'h1AA_AAAA);
    repeat (34) step(1, 0, 0, 0, 25'h0);
    step(0, 0, 0, 0, 25'h0);
    step(1, 0, 0, 0, 25'h0);
    step(1, 1, 8, 8, 25'h1F0_001F);
    drain();

    // Request in the done cycle with nothing pending: back-to-back frames.
    step(1, 1, 3, 6, 25'h0F0_0F0F);
    repeat (50) step(1, 0, 0, 0, 25'h0);
    step(1, 1, 12, 2, 25'h155_AAAA);
    drain();

    // Random traffic with occasional out-of-range tiles and resets.
    g = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (rst) g = 0;
      else if ($urandom_range(0, 5) == 0) g = ~g;
      if ($urandom_range(0, 19) == 0) begin
        x = $urandom_range(0, 255);
        y = $urandom_range(0, 127);
      end else begin
        x = $urandom_range(0, 26);
        y = $urandom_range(0, 23);
      end
      // Repeat the previous tile now and then to exercise same-tile frames.
      if ($urandom_range(0, 7) == 0) begin
        x = m_prev_x;
        y = m_prev_y;
      end
      s = 25'($urandom);
      step(!rst, g, x, y, s);
    end
    step(1, 0, 0, 0, 25'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
